bcd_rtc_core: RTL and testbench

Parametrised BCD time-of-day counter; successor to the free-running hh:mm:ss block. Adds an internal seconds prescaler, a selectable 12/24-hour format, validated load with a one-cycle acknowledge, and carry strobes. Sits between the system clock tree and the display/alarm logic; supplies packed BCD time to downstream consumers.

---
 rtl/bcd_rtc_core.sv | 172 +++++++++++++++++
 tb/tb_bcd_rtc_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_rtc_core.sv
// BCD hh:mm:ss time-of-day counter with seconds prescaler, 12/24h format, validated load and carry strobes.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module bcd_rtc_core #(
  parameter int CLK_PER_SEC = 4,
  parameter int TWELVE_HOUR = 0,
  parameter int PRESC_W     = 32
) (
  input  logic        d_clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        set,
  input  logic [7:0]  set_hour,
  input  logic [7:0]  set_min,
  input  logic [7:0]  set_sec,
  input  logic        set_pm,
`ifdef RTC_ALARM_EN
  input  logic        alarm_set,
  input  logic [7:0]  alarm_hour,
  input  logic [7:0]  alarm_min,
  input  logic        alarm_pm,
  output logic        alarm_hit,
`endif
  output logic        set_ack,
  output logic        set_err,
  output logic [7:0]  real_hour,
  output logic [7:0]  real_min,
  output logic [7:0]  real_sec,
  output logic        pm,
  output logic [23:0] full_time,
  output logic        sec_tick,
  output logic        min_carry,
  output logic        day_carry
);

  localparam logic [PRESC_W-1:0] TERM       = PRESC_W'(CLK_PER_SEC - 1);
  localparam logic [7:0]         RESET_HOUR = (TWELVE_HOUR != 0) ? 8'h12 : 8'h00;

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               load;
  logic               sec_wrap;
  logic               min_wrap;
  logic               day_wrap;
  logic [7:0]         nxt_sec;
  logic [7:0]         nxt_min;
  logic [7:0]         nxt_hour;
  logic               nxt_pm;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic valid_ms(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic valid_hour(input logic [7:0] v);
    if (TWELVE_HOUR != 0)
      return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
             ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    else
      return ((v[7:4] <= 4'd1) && (v[3:0] <= 4'd9)) ||
             ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
  endfunction

  assign tick      = en && (presc == TERM);
  assign load      = set && valid_hour(set_hour) && valid_ms(set_min) && valid_ms(set_sec);
  assign full_time = {real_hour, real_min, real_sec};

  // Successor time for a second advance; only committed when tick wins over load.
  always_comb begin
    sec_wrap = (real_sec == 8'h59);
    min_wrap = sec_wrap && (real_min == 8'h59);
    nxt_sec  = sec_wrap ? 8'h00 : bcd_inc(real_sec);
    nxt_min  = real_min;
    nxt_hour = real_hour;
    nxt_pm   = pm;
    day_wrap = 1'b0;
    if (sec_wrap) nxt_min = min_wrap ? 8'h00 : bcd_inc(real_min);
    if (min_wrap) begin
      if (TWELVE_HOUR != 0) begin
        if (real_hour == 8'h11) begin
          nxt_hour = 8'h12;
          nxt_pm   = ~pm;
          day_wrap = pm;
        end else if (real_hour == 8'h12) begin
          nxt_hour = 8'h01;
        end else begin
          nxt_hour = bcd_inc(real_hour);
        end
      end else if (real_hour == 8'h23) begin
        nxt_hour = 8'h00;
        day_wrap = 1'b1;
      end else begin
        nxt_hour = bcd_inc(real_hour);
      end
    end
  end

  always_ff @(posedge d_clk) begin
    if (!rst_n) begin
      presc     <= '0;
      real_sec  <= 8'h00;
      real_min  <= 8'h00;
      real_hour <= RESET_HOUR;
      pm        <= 1'b0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      day_carry <= 1'b0;
    end else begin
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      day_carry <= 1'b0;
      if (load) begin
        // A coincident tick is dropped so the loaded time starts a fresh second.
        real_hour <= set_hour;
        real_min  <= set_min;
        real_sec  <= set_sec;
        pm        <= (TWELVE_HOUR != 0) && set_pm;
        presc     <= '0;
        set_ack   <= 1'b1;
      end else begin
        if (set) set_err <= 1'b1;
        if (tick) begin
          presc     <= '0;
          real_sec  <= nxt_sec;
          real_min  <= nxt_min;
          real_hour <= nxt_hour;
          pm        <= nxt_pm;
          sec_tick  <= 1'b1;
          min_carry <= sec_wrap;
          day_carry <= day_wrap;
        end else if (en) begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0] alarm_h;
  logic [7:0] alarm_m;
  logic       alarm_p;
  logic       alarm_armed;

  always_ff @(posedge d_clk) begin
    if (!rst_n) begin
      alarm_h     <= 8'h00;
      alarm_m     <= 8'h00;
      alarm_p     <= 1'b0;
      alarm_armed <= 1'b0;
      alarm_hit   <= 1'b0;
    end else begin
      alarm_hit <= tick && !load && alarm_armed && (nxt_sec == 8'h00) &&
                   (nxt_min == alarm_m) && (nxt_hour == alarm_h) &&
                   ((TWELVE_HOUR == 0) || (nxt_pm == alarm_p));
      if (alarm_set && valid_hour(alarm_hour) && valid_ms(alarm_min)) begin
        alarm_h     <= alarm_hour;
        alarm_m     <= alarm_min;
        alarm_p     <= (TWELVE_HOUR != 0) && alarm_pm;
        alarm_armed <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcd_rtc_core.sv
// Scoreboard bench for bcd_rtc_core: a 24h and a 12h instance, expected events queued by stimulus,
// popped and compared by per-instance monitors whenever sec_tick, set_ack or set_err fires.
module tb_bcd_rtc_core;

  localparam logic [2:0] K_TICK = 3'b100;
  localparam logic [2:0] K_ACK  = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b001;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  kind;
    logic [23:0] t;
    logic [23:0] ft;
    logic        p;
    logic        mc;
    logic        dc;
  } exp_t;

  logic d_clk = 1'b0;
  logic rst_n;

  logic        en24, set24, set_pm24;
  logic [7:0]  sh24, sm24, ss24;
  logic        ack24, err24, pm24, tick24, mc24, dc24;
  logic [7:0]  hour24, min24, sec24;
  logic [23:0] ft24;

  logic        en12, set12, set_pm12;
  logic [7:0]  sh12, sm12, ss12;
  logic        ack12, err12, pm12, tick12, mc12, dc12;
  logic [7:0]  hour12, min12, sec12;
  logic [23:0] ft12;

  exp_t q24[$];
  exp_t q12[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  bcd_rtc_core #(.CLK_PER_SEC(4), .TWELVE_HOUR(0), .PRESC_W(32)) u_dut24 (
    .d_clk(d_clk), .rst_n(rst_n), .en(en24), .set(set24),
    .set_hour(sh24), .set_min(sm24), .set_sec(ss24), .set_pm(set_pm24),
    .set_ack(ack24), .set_err(err24),
    .real_hour(hour24), .real_min(min24), .real_sec(sec24), .pm(pm24),
    .full_time(ft24), .sec_tick(tick24), .min_carry(mc24), .day_carry(dc24)
  );

  bcd_rtc_core #(.CLK_PER_SEC(4), .TWELVE_HOUR(1), .PRESC_W(32)) u_dut12 (
    .d_clk(d_clk), .rst_n(rst_n), .en(en12), .set(set12),
    .set_hour(sh12), .set_min(sm12), .set_sec(ss12), .set_pm(set_pm12),
    .set_ack(ack12), .set_err(err12),
    .real_hour(hour12), .real_min(min12), .real_sec(sec12), .pm(pm12),
    .full_time(ft12), .sec_tick(tick12), .min_carry(mc12), .day_carry(dc12)
  );

  always #5 d_clk = ~d_clk;

  always @(posedge d_clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input logic [2:0] k, input logic [23:0] t,
                              input logic p, input logic mc, input logic dc);
    exp_t e;
    e.cyc  = 32'(c);
    e.kind = k;
    e.t    = t;
    e.ft   = t;
    e.p    = p;
    e.mc   = mc;
    e.dc   = dc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e, input exp_t o);
    compared++;
    if (o !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got cyc=%0d kind=%b time=%h ft=%h pm=%b mc=%b dc=%b, expected cyc=%0d kind=%b time=%h ft=%h pm=%b mc=%b dc=%b",
               name, o.cyc, o.kind, o.t, o.ft, o.p, o.mc, o.dc,
               e.cyc, e.kind, e.t, e.ft, e.p, e.mc, e.dc);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge d_clk);
    #1;
  endtask

  task automatic applyStimulus(input bit twelve, input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s, input logic p);
    if (twelve) begin
      set12 = 1'b1; sh12 = h; sm12 = m; ss12 = s; set_pm12 = p;
    end else begin
      set24 = 1'b1; sh24 = h; sm24 = m; ss24 = s; set_pm24 = p;
    end
    step(1);
    set12 = 1'b0;
    set24 = 1'b0;
  endtask

  always @(negedge d_clk) begin : mon24
    exp_t o;
    if (tick24 === 1'b1 || ack24 === 1'b1 || err24 === 1'b1) begin
      o.cyc = 32'(cyc); o.kind = {tick24, ack24, err24}; o.t = {hour24, min24, sec24};
      o.ft = ft24; o.p = pm24; o.mc = mc24; o.dc = dc24;
      if (q24.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_event24: got kind=%b time=%h at cyc=%0d, expected no event", o.kind, o.t, cyc);
      end else begin
        checkOutput("event24", q24.pop_front(), o);
      end
    end
  end

  always @(negedge d_clk) begin : mon12
    exp_t o;
    if (tick12 === 1'b1 || ack12 === 1'b1 || err12 === 1'b1) begin
      o.cyc = 32'(cyc); o.kind = {tick12, ack12, err12}; o.t = {hour12, min12, sec12};
      o.ft = ft12; o.p = pm12; o.mc = mc12; o.dc = dc12;
      if (q12.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_event12: got kind=%b time=%h at cyc=%0d, expected no event", o.kind, o.t, cyc);
      end else begin
        checkOutput("event12", q12.pop_front(), o);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en24 = 1'b0; set24 = 1'b0; sh24 = 8'h00; sm24 = 8'h00; ss24 = 8'h00; set_pm24 = 1'b0;
    en12 = 1'b0; set12 = 1'b0; sh12 = 8'h00; sm12 = 8'h00; ss12 = 8'h00; set_pm12 = 1'b0;
    step(3);
    checkValue("rst24_time", {8'h00, hour24, min24, sec24}, 32'h0);
    checkValue("rst24_ft", {8'h00, ft24}, 32'h0);
    checkValue("rst24_pulses", {26'd0, tick24, ack24, err24, mc24, dc24, pm24}, 32'h0);
    checkValue("rst12_time_pm", {7'd0, hour12, min12, sec12, pm12}, {7'd0, 8'h12, 8'h00, 8'h00, 1'b0});

    // Free run from reset: four ticks in sixteen cycles.
    rst_n = 1'b1;
    en24  = 1'b1;
    for (int i = 1; i <= 4; i++) q24.push_back(mk(cyc + 4 * i, K_TICK, 24'(i), 1'b0, 1'b0, 1'b0));
    step(16);
    en24 = 1'b0;
    checkValue("run16_sec", {24'd0, sec24}, 32'h04);
    checkValue("run16_ft", {8'h00, ft24}, 32'h000004);

    // Day rollover in 24h.
    q24.push_back(mk(cyc + 1, K_ACK, 24'h235958, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h23, 8'h59, 8'h58, 1'b0);
    en24 = 1'b1;
    q24.push_back(mk(cyc + 4, K_TICK, 24'h235959, 1'b0, 1'b0, 1'b0));
    q24.push_back(mk(cyc + 8, K_TICK, 24'h000000, 1'b0, 1'b1, 1'b1));
    step(8);
    en24 = 1'b0;

    // Rejected loads leave time untouched.
    q24.push_back(mk(cyc + 1, K_ERR, 24'h000000, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h10, 8'h60, 8'h00, 1'b0);
    q24.push_back(mk(cyc + 1, K_ERR, 24'h000000, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h1A, 8'h00, 8'h00, 1'b0);
    q24.push_back(mk(cyc + 1, K_ERR, 24'h000000, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h24, 8'h00, 8'h00, 1'b0);
    q24.push_back(mk(cyc + 1, K_ERR, 24'h000000, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h12, 8'h00, 8'h5A, 1'b0);

    // Hour BCD carry 09 -> 10.
    q24.push_back(mk(cyc + 1, K_ACK, 24'h095959, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h09, 8'h59, 8'h59, 1'b0);
    en24 = 1'b1;
    q24.push_back(mk(cyc + 4, K_TICK, 24'h100000, 1'b0, 1'b1, 1'b0));
    step(4);
    en24 = 1'b0;

    // Load coinciding with the terminal prescaler count.
    en24 = 1'b1;
    step(3);
    q24.push_back(mk(cyc + 1, K_ACK, 24'h102030, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 8'h10, 8'h20, 8'h30, 1'b0);
    q24.push_back(mk(cyc + 4, K_TICK, 24'h102031, 1'b0, 1'b0, 1'b0));
    step(4);

    // Reset mid-count overrides both en and set.
    step(2);
    rst_n = 1'b0;
    set24 = 1'b1; sh24 = 8'h05; sm24 = 8'h05; ss24 = 8'h05;
    step(1);
    set24 = 1'b0;
    checkValue("midrst_time", {8'h00, hour24, min24, sec24}, 32'h0);
    checkValue("midrst_pulses", {26'd0, tick24, ack24, err24, mc24, dc24, pm24}, 32'h0);
    rst_n = 1'b1;
    q24.push_back(mk(cyc + 4, K_TICK, 24'h000001, 1'b0, 1'b0, 1'b0));
    step(4);
    en24 = 1'b0;

    // 12h format: noon, 1 o'clock, midnight.
    q12.push_back(mk(cyc + 1, K_ACK, 24'h115959, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 8'h11, 8'h59, 8'h59, 1'b0);
    en12 = 1'b1;
    q12.push_back(mk(cyc + 4, K_TICK, 24'h120000, 1'b1, 1'b1, 1'b0));
    step(4);
    en12 = 1'b0;
    q12.push_back(mk(cyc + 1, K_ACK, 24'h125959, 1'b1, 1'b0, 1'b0));
    applyStimulus(1'b1, 8'h12, 8'h59, 8'h59, 1'b1);
    en12 = 1'b1;
    q12.push_back(mk(cyc + 4, K_TICK, 24'h010000, 1'b1, 1'b1, 1'b0));
    step(4);
    en12 = 1'b0;
    q12.push_back(mk(cyc + 1, K_ACK, 24'h115959, 1'b1, 1'b0, 1'b0));
    applyStimulus(1'b1, 8'h11, 8'h59, 8'h59, 1'b1);
    en12 = 1'b1;
    q12.push_back(mk(cyc + 4, K_TICK, 24'h120000, 1'b0, 1'b1, 1'b1));
    step(4);
    en12 = 1'b0;
    q12.push_back(mk(cyc + 1, K_ERR, 24'h120000, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    q12.push_back(mk(cyc + 1, K_ERR, 24'h120000, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 8'h13, 8'h00, 8'h00, 1'b0);

    step(4);
    checkValue("q24_drained", 32'(q24.size()), 32'd0);
    checkValue("q12_drained", 32'(q12.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
